// File: rtl/rotemp_uart_cmd_rx_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rotemp_uart_cmd_rx_if
// Description : Bundle of the serial input and every decoded output of the
//               UART command receiver.
//               master - host side: drives rx, observes everything else.
//               slave  - receiver side: samples rx, drives the outputs.
// Signals     : rx           serial line (idles high)
//               rx_data      last good byte       rx_valid   good-frame pulse
//               frame_err    bad-stop pulse       busy       frame in progress
//               cfg_*        sensor config bits   meas_window window register
//               start_meas   start pulse          read_req   read-back pulse
//               cmd_err      unknown-opcode pulse
// Revision    : 1.0 - initial release
// ============================================================================
interface rotemp_uart_cmd_rx_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;
  logic       cfg_osc_sel;
  logic       cfg_en_inv;
  logic       cfg_en_nand;
  logic       cfg_clk_sel;
  logic [7:0] meas_window;
  logic       start_meas;
  logic       read_req;
  logic       cmd_err;

  modport master (
    output rx,
    input  rx_data, rx_valid, frame_err, busy,
    input  cfg_osc_sel, cfg_en_inv, cfg_en_nand, cfg_clk_sel,
    input  meas_window, start_meas, read_req, cmd_err
  );

  modport slave (
    input  rx,
    output rx_data, rx_valid, frame_err, busy,
    output cfg_osc_sel, cfg_en_inv, cfg_en_nand, cfg_clk_sel,
    output meas_window, start_meas, read_req, cmd_err
  );
endinterface
`default_nettype wire

// File: rtl/rotemp_uart_cmd_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rotemp_uart_cmd_rx
// Description : 8N1 UART receiver plus byte-command decoder for the ring
//               oscillator temperature sensor. Opcodes: 'S' start measurement,
//               'R' read-back request, 'W' <byte> set measurement window,
//               'C' <byte> set config bits [3:0]. Anything else -> cmd_err.
// Ports       : clk    system clock
//               rst_n  asynchronous active-low reset
//               bus    rotemp_uart_cmd_rx_if.slave (rx in, all results out)
// Parameters  : CLKS_PER_BIT  clk cycles per UART bit, 4..1023
// Revision    : 1.0 - initial release
// ============================================================================
module rotemp_uart_cmd_rx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  rotemp_uart_cmd_rx_if.slave    bus
);

  localparam int         CNT_W       = 10;
  localparam logic [CNT_W-1:0] C_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] C_HALF_LAST = CNT_W'((CLKS_PER_BIT / 2) - 1);

  localparam logic [7:0] C_OP_START = 8'h53;  // 'S'
  localparam logic [7:0] C_OP_READ  = 8'h52;  // 'R'
  localparam logic [7:0] C_OP_WIN   = 8'h57;  // 'W'
  localparam logic [7:0] C_OP_CFG   = 8'h43;  // 'C'

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    P_IDLE  = 2'd0,
    P_ARG_W = 2'd1,
    P_ARG_C = 2'd2
  } p_state_t;

  // --------------------------------------------------------------------------
  // Input synchroniser. Both flops reset high so a line that is low when
  // reset releases still appears as a fresh falling edge to the RX FSM.
  // --------------------------------------------------------------------------
  logic r_rx_meta;
  logic r_rx_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= bus.rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // --------------------------------------------------------------------------
  // RX FSM
  // --------------------------------------------------------------------------
  rx_state_t         r_rx_state;
  logic [CNT_W-1:0]  r_clk_cnt;
  logic [2:0]        r_bit_cnt;
  logic [7:0]        r_shift;
  logic [7:0]        r_rx_data;
  logic              r_rx_valid;
  logic              r_frame_err;
  logic              r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state  <= S_IDLE;
      r_clk_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_rx_state)
        S_IDLE: begin
          if (!r_rx_sync) begin
            r_rx_state <= S_START;
            r_clk_cnt  <= '0;
            r_bit_cnt  <= '0;
          end
        end
        S_START: begin
          // Re-sample mid start bit; a high line here was only a glitch.
          if (r_clk_cnt == C_HALF_LAST) begin
            r_clk_cnt <= '0;
            if (!r_rx_sync) begin
              r_rx_state <= S_DATA;
              r_busy     <= 1'b1;
            end else begin
              r_rx_state <= S_IDLE;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (r_clk_cnt == C_BIT_LAST) begin
            r_clk_cnt <= '0;
            r_shift   <= {r_rx_sync, r_shift[7:1]};  // LSB arrives first
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_rx_state <= S_STOP;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          // Leave for IDLE right at the stop sample so a start bit that
          // immediately follows is caught with no lost cycles.
          if (r_clk_cnt == C_BIT_LAST) begin
            r_clk_cnt  <= '0;
            r_busy     <= 1'b0;
            r_rx_state <= S_IDLE;
            if (r_rx_sync) begin
              r_rx_data  <= r_shift;
              r_rx_valid <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end
        default: r_rx_state <= S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Command parser. Consumes the registered rx_valid/rx_data pair, so every
  // parser output lands one cycle after rx_valid.
  // --------------------------------------------------------------------------
  p_state_t    r_p_state;
  logic [7:0]  r_meas_window;
  logic [3:0]  r_cfg;
  logic        r_start_meas;
  logic        r_read_req;
  logic        r_cmd_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p_state     <= P_IDLE;
      r_meas_window <= 8'h80;
      r_cfg         <= 4'h0;
      r_start_meas  <= 1'b0;
      r_read_req    <= 1'b0;
      r_cmd_err     <= 1'b0;
    end else begin
      r_start_meas <= 1'b0;
      r_read_req   <= 1'b0;
      r_cmd_err    <= 1'b0;
      if (r_rx_valid) begin
        case (r_p_state)
          P_IDLE: begin
            case (r_rx_data)
              C_OP_START: r_start_meas <= 1'b1;
              C_OP_READ:  r_read_req   <= 1'b1;
              C_OP_WIN:   r_p_state    <= P_ARG_W;
              C_OP_CFG:   r_p_state    <= P_ARG_C;
              default:    r_cmd_err    <= 1'b1;
            endcase
          end
          P_ARG_W: begin
            r_meas_window <= r_rx_data;
            r_p_state     <= P_IDLE;
          end
          P_ARG_C: begin
            r_cfg     <= r_rx_data[3:0];
            r_p_state <= P_IDLE;
          end
          default: r_p_state <= P_IDLE;
        endcase
      end else if (r_frame_err) begin
        // A corrupted argument byte drops the pending command silently.
        r_p_state <= P_IDLE;
      end
    end
  end

  assign bus.rx_data     = r_rx_data;
  assign bus.rx_valid    = r_rx_valid;
  assign bus.frame_err   = r_frame_err;
  assign bus.busy        = r_busy;
  assign bus.cfg_osc_sel = r_cfg[0];
  assign bus.cfg_en_inv  = r_cfg[1];
  assign bus.cfg_en_nand = r_cfg[2];
  assign bus.cfg_clk_sel = r_cfg[3];
  assign bus.meas_window = r_meas_window;
  assign bus.start_meas  = r_start_meas;
  assign bus.read_req    = r_read_req;
  assign bus.cmd_err     = r_cmd_err;

endmodule
`default_nettype wire
